// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcodes, FSM states and small decode helpers for the HI/LO mul/div sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'd0,
    MD_OP_MULTU = 2'd1,
    MD_OP_DIV   = 2'd2,
    MD_OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

  // Low word returned by the short-circuited divide-by-zero path.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier/divider: latches one op, stalls until {hi,lo} exists.
// Optional: define MULDIV_DIV0_FAST_EN to resolve DIV/DIVU by zero without starting the divider.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  input  logic        flush,
  input  logic        stall_hold,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        res_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state;
  md_state_e        state_nx;
  md_op_e           op_q;
  md_op_e           req_op_e;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             cap_mul;
  logic             cap_div;
`ifdef MULDIV_DIV0_FAST_EN
  logic             cap_div0;
`endif

  assign req_op_e = md_op_e'(req_op);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    cap_mul  = 1'b0;
    cap_div  = 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
    cap_div0 = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          load = 1'b1;
          if (op_is_div(req_op_e)) begin
`ifdef MULDIV_DIV0_FAST_EN
            if (req_opb == '0) begin
              state_nx = ST_DONE;
              cap_div0 = 1'b1;
            end else begin
              state_nx = ST_DIV_RUN;
            end
`else
            state_nx = ST_DIV_RUN;
`endif
          end else begin
            state_nx = ST_MUL_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (cnt == '0) begin
          cap_mul  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DIV_RUN: begin
        if (div_ready) begin
          cap_div  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!stall_hold) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // An abandoned op must not latch operands or commit a result.
    if (flush) begin
      state_nx = ST_IDLE;
      load     = 1'b0;
      cap_mul  = 1'b0;
      cap_div  = 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      cap_div0 = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= MD_OP_MULT;
      opa_q <= '0;
      opb_q <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load) begin
        op_q  <= req_op_e;
        opa_q <= req_opa;
        opb_q <= req_opb;
        cnt   <= CNT_W'(MUL_LAT - 1);
      end else if (state == ST_MUL_WAIT && cnt != '0 && !flush) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (cap_mul) begin
        hi <= mul_result[63:32];
        lo <= mul_result[31:0];
      end
      if (cap_div) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end
`ifdef MULDIV_DIV0_FAST_EN
      if (cap_div0) begin
        hi <= req_opa;
        lo <= DIV0_LO;
      end
`endif
    end
  end

  // Units only ever see the latched operands, and see zeros while idle.
  always_comb begin
    stallreq   = 1'b0;
    mul_signed = 1'b0;
    mul_ina    = '0;
    mul_inb    = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_opa    = '0;
    div_opb    = '0;
    div_annul  = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: stallreq = req_valid;
      ST_MUL_WAIT: begin
        stallreq   = 1'b1;
        mul_signed = op_is_signed(op_q);
        mul_ina    = opa_q;
        mul_inb    = opb_q;
      end
      ST_DIV_RUN: begin
        stallreq   = 1'b1;
        div_start  = 1'b1;
        div_signed = op_is_signed(op_q);
        div_opa    = opa_q;
        div_opb    = opb_q;
        div_annul  = flush;
      end
      ST_DONE: res_valid = !flush;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl with behavioural multiplier/divider stand-ins.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_opa = '0;
  logic [31:0] req_opb = '0;
  logic        flush = 1'b0;
  logic        stall_hold = 1'b0;
  logic        stallreq, mul_signed, div_start, div_signed, div_annul, div_ready, res_valid;
  logic [31:0] mul_ina, mul_inb, div_opa, div_opb, hi, lo;
  logic [63:0] mul_result, div_result, mul_pipe;

  int checks = 0;
  int errors = 0;
  int div_cyc = 33;
  int dcnt = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_opa(req_opa), .req_opb(req_opb), .flush(flush), .stall_hold(stall_hold),
    .stallreq(stallreq), .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
    .div_result(div_result), .res_valid(res_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return p;
  endfunction

  // Divider result is {rem, quot}; by-zero mimics a restoring divider: rem=dividend, quot=all ones.
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] op_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return mul_ref(1'b1, a, b);
      2'd1:    return mul_ref(1'b0, a, b);
      2'd2:    return div_ref(1'b1, a, b);
      default: return div_ref(1'b0, a, b);
    endcase
  endfunction

  // Multiplier stand-in: MUL_LAT-1 register stages behind stable operands.
  always @(posedge clk) mul_pipe <= mul_ref(mul_signed, mul_ina, mul_inb);
  assign mul_result = mul_pipe;

  // Divider stand-in: ready pulse in the div_cyc-th cycle of a continuous div_start.
  always @(posedge clk) begin
    if (rst || !div_start || div_annul || div_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_ready  = div_start && !div_annul && (dcnt == div_cyc - 1);
  assign div_result = div_ref(div_signed, div_opa, div_opb);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, follow it to DONE, hold DONE for 'hold' cycles, then let the pipe advance.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input int dcyc);
    logic [63:0] exp;
    logic        is_div, sgn, got, ok;
    int          stall_cnt, start_cnt, exp_stall, exp_start;
    exp       = op_ref(op, a, b);
    is_div    = op[1];
    sgn       = ~op[0];
    got       = 1'b0;
    ok        = 1'b1;
    stall_cnt = 0;
    start_cnt = 0;
    div_cyc   = dcyc;
    if (!is_div) begin
      exp_stall = MUL_LAT + 1;
      exp_start = 0;
    end else begin
`ifdef MULDIV_DIV0_FAST_EN
      exp_stall = (b == 0) ? 1 : dcyc + 1;
      exp_start = (b == 0) ? 0 : dcyc;
`else
      exp_stall = dcyc + 1;
      exp_start = dcyc;
`endif
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_opa = a; req_opb = b;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
      end else begin
        if (stallreq) stall_cnt++;
        if (div_start) start_cnt++;
        if (c >= 1) begin
          if (is_div)
            ok &= div_start && div_opa == a && div_opb == b && div_signed == sgn &&
                  mul_ina == 0 && mul_inb == 0 && !mul_signed;
          else
            ok &= mul_ina == a && mul_inb == b && mul_signed == sgn &&
                  !div_start && div_opa == 0 && div_opb == 0 && !div_signed;
          req_opa = $urandom;
          req_opb = $urandom;
        end
      end
    end
    if (!got) begin
      checkOutput("done_timeout", 64'(got), 64'd1);
      req_valid = 1'b0;
      return;
    end
    checkOutput("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    checkOutput("start_cycles", 64'(start_cnt), 64'(exp_start));
    checkOutput("unit_inputs", 64'(ok), 64'd1);
    checkOutput("hilo", {hi, lo}, exp);
    stall_hold = (hold > 0);
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_state", {hi, lo, 28'd0, res_valid, stallreq, div_start, div_annul},
                  {exp, 28'd0, 4'b1000});
    end
    stall_hold = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("released", {62'd0, res_valid, stallreq}, 64'd0);
  endtask

  task automatic flushDuringDiv(input int at_cycle);
    int  ann_cnt;
    logic res_seen;
    ann_cnt  = 0;
    res_seen = 1'b0;
    div_cyc  = 40;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd3; req_opa = 32'd1000; req_opb = 32'd3;
    @(negedge clk);
    for (int c = 1; c <= at_cycle; c++) begin
      @(negedge clk);
      if (div_annul) ann_cnt++;
      if (res_valid) res_seen = 1'b1;
    end
    flush = 1'b1;
    #1;
    checkOutput("annul_on_flush", 64'(div_annul), 64'd1);
    if (div_annul) ann_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (div_annul) ann_cnt++;
      if (res_valid) res_seen = 1'b1;
      checkOutput("after_flush", {61'd0, stallreq, div_start, res_valid}, 64'd0);
    end
    checkOutput("annul_count", 64'(ann_cnt), 64'd1);
    checkOutput("flush_no_result", 64'(res_seen), 64'd0);
  endtask

  task automatic resetMidMul();
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd0; req_opa = 32'd9; req_opb = 32'd9;
    @(posedge clk); #3;
    checkOutput("pre_reset_busy", 64'(stallreq), 64'd1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checkOutput("async_reset_outs",
                64'(|{stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
                      div_opa, div_opb, div_annul, res_valid, hi, lo}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    #12;
    checkOutput("reset_outs",
                64'(|{stallreq, mul_signed, mul_ina, mul_inb, div_start, div_signed,
                      div_opa, div_opb, div_annul, res_valid, hi, lo}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0, 33);
    checkOutput("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(2'd3, 32'd100, 32'd7, 0, 33);
    checkOutput("t2_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 5, 33);
    checkOutput("t3_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    flushDuringDiv(10);
    applyStimulus(2'd3, 32'h0000_002A, 32'd0, 1, 12);
    checkOutput("t5_hilo", {hi, lo}, 64'h0000_002A_FFFF_FFFF);
    resetMidMul();
    applyStimulus(2'd1, 32'd3, 32'd5, 0, 33);
    checkOutput("t6_lo", 64'(lo), 64'h0000_000F);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 0) a = 32'h8000_0000;
      applyStimulus(op, a, b, $urandom_range(0, 3), $urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
